c2_mem_responder: RTL and testbench
===================================

# c2_mem_responder

Synthesizable memory-side responder for the cache-to-memory C2 bus. It answers line reads and line writes issued by the cache controller and models a fixed access latency. It stores the backing memory as whole cache lines. It is the clocked, resettable counterpart to the cache's C2 initiator and sits directly below the cache in the CPU–cache–memory hierarchy.

## Interface
- LINE_ADDR_W, 15, line-address width; memory holds 2^LINE_ADDR_W lines
- LINE_BYTES, 16, bytes per cache line
- BUS_W, 16, C2 data-bus width in bits; BEATS = LINE_BYTES*8/BUS_W (8 by default)
- LATENCY, 100, cycles from command capture to the first response cycle; legal range 1..1023
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- c2_cmd_in  in  2  initiator command: NOP=0, RESPONSE=1 (unused inbound), READ_LINE=2, WRITE_LINE=3
- c2_addr  in  LINE_ADDR_W  line address, sampled on the command's first cycle only
- c2_data_in  in  BUS_W  write beat data
- c2_cmd_out  out  2  NOP or RESPONSE
- c2_data_out  out  BUS_W  read beat data
- busy  out  1  high in every state except IDLE
- err  out  1  sticky protocol-error flag (see Configuration)

## Operation
- States: IDLE, WR_BEATS, WAIT, RD_BEATS, WR_ACK.
- IDLE + READ_LINE: latch addr, copy the line into the line buffer, load the counter, go to WAIT (op=read).
- IDLE + WRITE_LINE: latch addr, store beat 0, go to WR_BEATS.
- WR_BEATS: store beats 1..BEATS-1 on consecutive cycles while the command stays WRITE_LINE. After the last beat, commit the whole line to the array in one cycle, load the counter, go to WAIT (op=write).
- WRITE_LINE deasserted mid-burst: abort, go to IDLE, commit nothing.
- WAIT: count down. At expiry go to RD_BEATS (read) or WR_ACK (write).
- RD_BEATS: drive RESPONSE with beat k on cycle k, for k = 0..BEATS-1, then go to IDLE.
- WR_ACK: drive RESPONSE for one cycle with c2_data_out=0, then go to IDLE.
- Beat order is little-endian: beat k carries line bytes 2k (low) and 2k+1 (high) for BUS_W=16.
- Commands arriving while busy are ignored. NOP in IDLE does nothing.
- Array contents are not reset. Benches preload them or write before reading.

## Timing
- All outputs are registered. Reset values: c2_cmd_out=NOP, c2_data_out=0, busy=0, err=0, state=IDLE.
- Read: command sampled at edge T0. Beat k is visible in the cycle after edge T0+LATENCY+k. The bus is back to NOP after edge T0+LATENCY+BEATS.
- Write: beats sampled at edges T0..T0+BEATS-1. The single RESPONSE is visible in the cycle after edge T0+BEATS-1+LATENCY.
- A new command is accepted on the first edge at which busy=0, which is the edge that returns the block to IDLE+1. A back-to-back command is therefore sampled one cycle after the last RESPONSE cycle.
- A read issued right after a write to the same line returns the new data, because the commit precedes WAIT.
- Reset asserted mid-operation: immediate return to IDLE with reset output values. A partially received write is discarded. Already-committed lines survive.
- Counter width is 10 bits. LATENCY=1 gives one WAIT cycle.

## Configuration
- C2_PROTO_CHECK_EN defined: err sets and stays set until reset on any of these events:
  - a non-NOP command while busy, except WRITE_LINE continuation inside WR_BEATS;
  - RESPONSE received on c2_cmd_in;
  - WRITE_LINE dropped mid-burst.
  Each event also issues $error with the state and the cycle count.
- C2_PROTO_CHECK_EN undefined: err is tied to 0 and no checking logic is generated. Functional behaviour is otherwise identical.

## Structure
- Package c2_pkg: c2_cmd_t enum (NOP, RESPONSE, READ_LINE, WRITE_LINE); LINE_BYTES, BUS_W, BEATS constants; state enum.
- Sub-module c2_line_store: 2^LINE_ADDR_W × LINE_BYTES*8 array with one line-wide synchronous read port and one line-wide synchronous write port. No reset.
- Top level holds the FSM, latency counter, beat index, and line buffer.

## Test plan
- Reset, then write line 0x0005 with beats 0x0100, 0x0302 … 0x0F0E -> single RESPONSE in the cycle after edge T0+7+100; busy low one cycle later.
- Read line 0x0005 -> eight RESPONSE cycles carrying 0x0100 … 0x0F0E in order, starting after edge T0+100; then NOP.
- READ_LINE issued during WAIT of a previous read -> ignored, only one burst occurs. With C2_PROTO_CHECK_EN, err=1.
- WRITE_LINE dropped after beat 3 to line 0x0007, which holds 0xAAAA in every beat -> no RESPONSE; a subsequent read returns 0xAAAA in all eight beats.
- reset_n pulsed low during RD_BEATS beat 4 -> c2_cmd_out=NOP and busy=0 immediately; a re-read returns the full, correct line.
- LATENCY=1 build: write then read line 0 with back-to-back commands -> write ack after edge T0+8, read beat 0 visible three cycles after the ack.

Source files
------------

// File: rtl/c2_pkg.sv
// Shared C2 bus types and default geometry for the memory-side responder.
package c2_pkg;

    localparam int LINE_BYTES = 16;
    localparam int BUS_W      = 16;
    localparam int BEATS      = LINE_BYTES * 8 / BUS_W;

    typedef enum logic [1:0] {
        NOP        = 2'd0,
        RESPONSE   = 2'd1,
        READ_LINE  = 2'd2,
        WRITE_LINE = 2'd3
    } c2_cmd_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BEATS = 3'd1,
        WAIT     = 3'd2,
        RD_BEATS = 3'd3,
        WR_ACK   = 3'd4
    } c2_state_t;

endpackage

// File: rtl/c2_line_store.sv
// Whole-line backing array: one line-wide synchronous read port, one line-wide write port, no reset.
module c2_line_store #(
    parameter int ADDR_W = 15,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [LINE_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [LINE_W-1:0] i_wr_data
);

    logic [LINE_W-1:0] r_mem [2**ADDR_W];
    logic [LINE_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/c2_mem_responder.sv
// C2 memory responder: line reads/writes with a fixed access latency and registered outputs.
// Define C2_PROTO_CHECK_EN to build the sticky protocol-error flag (err); otherwise err is tied low.
module c2_mem_responder #(
    parameter int LINE_ADDR_W = 15,
    parameter int LINE_BYTES  = 16,
    parameter int BUS_W       = 16,
    parameter int LATENCY     = 100
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             c2_cmd_in,
    input  logic [LINE_ADDR_W-1:0] c2_addr,
    input  logic [BUS_W-1:0]       c2_data_in,
    output logic [1:0]             c2_cmd_out,
    output logic [BUS_W-1:0]       c2_data_out,
    output logic                   busy,
    output logic                   err
);
    import c2_pkg::c2_cmd_t, c2_pkg::c2_state_t;
    import c2_pkg::NOP, c2_pkg::RESPONSE, c2_pkg::READ_LINE, c2_pkg::WRITE_LINE;
    import c2_pkg::IDLE, c2_pkg::WR_BEATS, c2_pkg::WAIT, c2_pkg::RD_BEATS, c2_pkg::WR_ACK;

    localparam int             BEATS    = LINE_BYTES * 8 / BUS_W;
    localparam int             LINE_W   = LINE_BYTES * 8;
    localparam int             IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [9:0]     LAT_LOAD = 10'(LATENCY - 1);

    c2_state_t                      r_state;
    c2_cmd_t                        r_cmd_out;
    logic [BUS_W-1:0]               r_data_out;
    logic                           r_op_rd;
    logic [9:0]                     r_cnt;
    logic [IDX_W-1:0]               r_idx;
    logic [LINE_ADDR_W-1:0]         r_addr;
    logic [BEATS-1:0][BUS_W-1:0]    r_line;
    logic [BEATS-1:0][BUS_W-1:0]    w_rd_line;
    logic [BEATS-1:0][BUS_W-1:0]    w_wr_line;
    c2_cmd_t                        w_cmd;
    logic                           w_rd_en;
    logic                           w_last_beat;

    assign w_cmd       = c2_cmd_t'(c2_cmd_in);
    assign w_rd_en     = (r_state == IDLE) && (w_cmd == READ_LINE);
    assign w_last_beat = (r_state == WR_BEATS) && (w_cmd == WRITE_LINE) && (r_idx == LAST_IDX);

    // The final beat goes straight into the committed line so the array is current before WAIT.
    always_comb begin
        w_wr_line        = r_line;
        w_wr_line[r_idx] = c2_data_in;
    end

    c2_line_store #(.ADDR_W(LINE_ADDR_W), .LINE_W(LINE_W)) u_store (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (c2_addr),
        .o_rd_data (w_rd_line),
        .i_wr_en   (w_last_beat),
        .i_wr_addr (r_addr),
        .i_wr_data (w_wr_line)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cmd_out  <= NOP;
            r_data_out <= '0;
            r_op_rd    <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_line     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd == READ_LINE) begin
                        r_addr  <= c2_addr;
                        r_op_rd <= 1'b1;
                        r_cnt   <= LAT_LOAD;
                        r_state <= WAIT;
                    end else if (w_cmd == WRITE_LINE) begin
                        r_addr    <= c2_addr;
                        r_line[0] <= c2_data_in;
                        r_idx     <= IDX_W'(1);
                        r_op_rd   <= 1'b0;
                        r_state   <= WR_BEATS;
                    end
                end
                WR_BEATS: begin
                    if (w_cmd != WRITE_LINE) begin
                        r_state <= IDLE;
                    end else begin
                        r_line[r_idx] <= c2_data_in;
                        if (w_last_beat) begin
                            r_cnt   <= LAT_LOAD;
                            r_state <= WAIT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cmd_out <= RESPONSE;
                        // Store read data has been stable since the command; buffer it and emit beat 0.
                        if (r_op_rd) begin
                            r_line     <= w_rd_line;
                            r_data_out <= w_rd_line[0];
                            r_idx      <= '0;
                            r_state    <= RD_BEATS;
                        end else begin
                            r_data_out <= '0;
                            r_state    <= WR_ACK;
                        end
                    end
                end
                RD_BEATS: begin
                    if (r_idx == LAST_IDX) begin
                        r_cmd_out  <= NOP;
                        r_data_out <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_data_out <= r_line[r_idx + 1'b1];
                        r_idx      <= r_idx + 1'b1;
                    end
                end
                WR_ACK: begin
                    r_cmd_out <= NOP;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign c2_cmd_out  = r_cmd_out;
    assign c2_data_out = r_data_out;

`ifdef C2_PROTO_CHECK_EN
    logic        r_err;
    logic [31:0] r_cycle;
    logic        w_busy_cmd;
    logic        w_drop;
    logic        w_evt;

    assign w_busy_cmd = (r_state != IDLE) && (w_cmd != NOP) &&
                        !((r_state == WR_BEATS) && (w_cmd == WRITE_LINE));
    assign w_drop     = (r_state == WR_BEATS) && (w_cmd != WRITE_LINE);
    assign w_evt      = w_busy_cmd || w_drop || (w_cmd == RESPONSE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err   <= 1'b0;
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_evt) begin
                r_err <= 1'b1;
                $error("c2_mem_responder: protocol error in state %s at cycle %0d",
                       r_state.name(), r_cycle);
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_c2_mem_responder.sv
// Randomized scoreboard bench for c2_mem_responder against a line-level memory model.
module tb_c2_mem_responder;

    localparam int AW  = 15;
    localparam int LB  = 16;
    localparam int BW  = 16;
    localparam int LAT = 100;
    localparam int NB  = LB * 8 / BW;
    localparam int LW  = LB * 8;
`ifdef C2_PROTO_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    cmd_in  = 2'd0;
    logic [AW-1:0] addr    = '0;
    logic [BW-1:0] din     = '0;
    logic [1:0]    cmd_out;
    logic [BW-1:0] dout;
    logic          busy;
    logic          err;

    c2_mem_responder #(.LINE_ADDR_W(AW), .LINE_BYTES(LB), .BUS_W(BW), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .c2_cmd_in   (cmd_in),
        .c2_addr     (addr),
        .c2_data_in  (din),
        .c2_cmd_out  (cmd_out),
        .c2_data_out (dout),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned   stamp;
        logic [BW-1:0] data;
    } exp_t;

    exp_t          expq[$];
    logic [LW-1:0] model[int];
    int            wr_list[$];
    int            n_chk   = 0;
    int            n_err   = 0;
    bit            err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, got, want, edge_n);
        end
    endtask

    // Monitor: every RESPONSE cycle must match the oldest expected beat, value and edge alike.
    exp_t m_e;
    always @(negedge clk) begin
        if (reset_n) begin
            if (cmd_out == 2'd1) begin
                n_chk++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL resp_unexpected: got data 0x%0h at edge %0d, none expected", dout, edge_n);
                end else begin
                    m_e = expq.pop_front();
                    if (dout !== m_e.data || edge_n != m_e.stamp) begin
                        n_err++;
                        $display("FAIL resp: got 0x%0h at edge %0d expected 0x%0h at edge %0d",
                                 dout, edge_n, m_e.data, m_e.stamp);
                    end
                end
            end else if (expq.size() != 0 && expq[0].stamp < edge_n) begin
                n_chk++;
                n_err++;
                m_e = expq.pop_front();
                $display("FAIL resp_missing: no RESPONSE, expected 0x%0h at edge %0d", m_e.data, m_e.stamp);
            end
        end
    end

    task automatic wait_edge(input int unsigned e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic inject_spur(input int unsigned at, input logic [1:0] c);
        wait_edge(at);
        cmd_in = c;
        addr   = AW'($urandom);
        @(negedge clk);
        cmd_in = 2'd0;
        if (PCHK) err_exp = 1'b1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] line,
                            input int nbeats, input bit spur);
        int unsigned t0;
        exp_t        e;
        t0     = edge_n + 1;
        cmd_in = 2'd3;
        addr   = a;
        din    = line[BW-1:0];
        for (int k = 1; k < nbeats; k++) begin
            @(negedge clk);
            din = line[k*BW +: BW];
        end
        @(negedge clk);
        cmd_in = 2'd0;
        din    = '0;
        if (nbeats < NB) begin
            @(negedge clk);
            check("abort_busy", busy, 0);
            if (PCHK) err_exp = 1'b1;
        end else begin
            e.stamp = t0 + NB - 1 + LAT;
            e.data  = '0;
            expq.push_back(e);
            if (!model.exists(int'(a))) wr_list.push_back(int'(a));
            model[int'(a)] = line;
            if (spur) inject_spur(t0 + NB + 5 + $urandom_range(0, LAT - 20), 2'($urandom_range(2, 3)));
            wait_edge(e.stamp);
            check("ack_busy", busy, 1);
            @(negedge clk);
            check("after_ack_busy", busy, 0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit spur, input int rst_beat);
        int unsigned   t0;
        exp_t          e;
        logic [LW-1:0] line;
        t0     = edge_n + 1;
        cmd_in = 2'd2;
        addr   = a;
        @(negedge clk);
        cmd_in = 2'd0;
        line   = model[int'(a)];
        for (int k = 0; k < NB; k++) begin
            e.stamp = t0 + LAT + k;
            e.data  = line[k*BW +: BW];
            expq.push_back(e);
        end
        if (spur) inject_spur(t0 + 2 + $urandom_range(0, LAT - 20), 2'd2);
        if (rst_beat >= 0) begin
            wait_edge(t0 + LAT + rst_beat);
            #2 reset_n = 1'b0;
            #1;
            check("rst_cmd_nop", cmd_out, 0);
            check("rst_busy", busy, 0);
            check("rst_data", dout, 0);
            check("rst_err", err, 0);
            expq.delete();
            err_exp = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
        end else begin
            wait_edge(t0 + LAT + NB);
            check("rd_end_nop", cmd_out, 0);
            check("rd_end_busy", busy, 0);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return AW'(5);
            3:       return AW'(7);
            default: return AW'($urandom);
        endcase
    endfunction

    logic [LW-1:0] l5;
    logic [LW-1:0] la;
    logic [AW-1:0] ra;
    int            op;

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cmd", cmd_out, 0);
        check("reset_data", dout, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NB; k++) l5[k*BW +: BW] = {8'(2*k + 1), 8'(2*k)};
        for (int k = 0; k < NB; k++) la[k*BW +: BW] = 16'hAAAA;
        do_write(AW'(5), l5, NB, 1'b0);
        do_read(AW'(5), 1'b0, -1);
        do_read(AW'(5), 1'b1, -1);
        do_write(AW'(7), la, NB, 1'b0);
        do_write(AW'(7), rand_line(), 4, 1'b0);
        do_read(AW'(7), 1'b0, -1);
        do_read(AW'(5), 1'b0, 4);
        do_read(AW'(5), 1'b0, -1);
        do_write('0, rand_line(), NB, 1'b0);
        do_read('0, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 3));
            ra = pick_addr();
            if (op == 0 || wr_list.size() == 0) begin
                do_write(ra, rand_line(), NB, 1'($urandom_range(0, 1)));
            end else if (op == 2) begin
                do_write(ra, rand_line(), int'($urandom_range(1, NB - 1)), 1'b0);
            end else begin
                do_read(AW'(wr_list[$urandom_range(0, wr_list.size() - 1)]), op == 3, -1);
            end
        end

        for (int i = 0; i < 2 * LAT + 20 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d responses still outstanding, required 0", expq.size());
        end
        check("final_err", err, err_exp);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
